// File: rtl/cmac_msg_sequencer.sv
// Packs a streamed message into 128-bit blocks for cmac_core, sequences init/next/finalize,
// and presents the resulting tag on a valid/ready port.
module cmac_msg_sequencer #(
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned BW     = $clog2(DATA_W/8) + 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [DATA_W-1:0] s_data,
   input  logic [BW-1:0]     s_bytes,
   input  logic              s_last,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              core_init,
   output logic              core_next,
   output logic              core_finalize,
   output logic [7:0]        core_final_size,
   output logic [127:0]      core_block,
   input  logic              core_ready,
   input  logic              core_valid,
   input  logic [127:0]      core_result,
   output logic [127:0]      tag,
   output logic              tag_valid,
   input  logic              tag_ready,
   output logic              busy
);

   localparam int unsigned BLK_BYTES = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_WAIT_I,
      S_COLLECT,
      S_ISSUE,
      S_WAIT_N,
      S_TAG
   } state_t;

   state_t       r_state;
   logic [127:0] r_buf;
   logic [4:0]   r_cnt;
   logic         r_fin;

   logic [127:0] w_word;
   logic [127:0] w_mask;
   logic [127:0] w_ins;
   logic [127:0] w_buf_nxt;
   logic [4:0]   w_cnt_nxt;
   logic         w_accept;
   logic         w_blk_done;

   // Word aligned to the block MSBs, bytes past s_bytes zeroed, then moved down to offset cnt.
   assign w_word     = 128'(s_data) << (128 - DATA_W);
   assign w_mask     = ~({128{1'b1}} >> {s_bytes, 3'b000});
   assign w_ins      = (w_word & w_mask) >> {r_cnt, 3'b000};
   assign w_buf_nxt  = r_buf | w_ins;
   assign w_cnt_nxt  = r_cnt + 5'(s_bytes);
   assign w_accept   = (r_state == S_COLLECT) & s_valid & s_ready;
   assign w_blk_done = s_last | (w_cnt_nxt >= 5'(BLK_BYTES));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state         <= S_IDLE;
         r_buf           <= '0;
         r_cnt           <= '0;
         r_fin           <= 1'b0;
         s_ready         <= 1'b0;
         core_init       <= 1'b0;
         core_next       <= 1'b0;
         core_finalize   <= 1'b0;
         core_final_size <= '0;
         core_block      <= '0;
         tag             <= '0;
         tag_valid       <= 1'b0;
         busy            <= 1'b0;
      end else begin
         core_init <= 1'b0;
         core_next <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_INIT;
                  core_init <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            S_INIT: r_state <= S_WAIT_I;
            S_WAIT_I: begin
               if (core_ready) begin
                  r_state <= S_COLLECT;
                  s_ready <= 1'b1;
               end
            end
            S_COLLECT: begin
               if (w_accept) begin
                  r_buf <= w_buf_nxt;
                  r_cnt <= w_cnt_nxt;
                  // A full block that also carries s_last goes out as the final block.
                  if (w_blk_done) begin
                     r_state         <= S_ISSUE;
                     s_ready         <= 1'b0;
                     core_next       <= 1'b1;
                     core_block      <= w_buf_nxt;
                     r_fin           <= s_last;
                     core_finalize   <= s_last;
                     core_final_size <= s_last ? {w_cnt_nxt, 3'b000} : 8'd128;
                  end
               end
            end
            S_ISSUE: r_state <= S_WAIT_N;
            S_WAIT_N: begin
               if (core_ready) begin
                  r_buf <= '0;
                  r_cnt <= '0;
                  if (r_fin) begin
                     tag       <= core_valid ? core_result : '0;
                     tag_valid <= 1'b1;
                     r_state   <= S_TAG;
                  end else begin
                     s_ready <= 1'b1;
                     r_state <= S_COLLECT;
                  end
               end
            end
            S_TAG: begin
               if (tag_ready) begin
                  tag_valid <= 1'b0;
                  busy      <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmac_msg_sequencer.sv
// Directed bench for cmac_msg_sequencer with a behavioural cmac_core stand-in.
`timescale 1ns/1ps
module tb_cmac_msg_sequencer;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         start = 1'b0;
   logic [31:0]  s_data = '0;
   logic [2:0]   s_bytes = '0;
   logic         s_last = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic         core_init, core_next, core_finalize;
   logic [7:0]   core_final_size;
   logic [127:0] core_block;
   logic         core_ready, core_valid;
   logic [127:0] core_result;
   logic [127:0] tag;
   logic         tag_valid;
   logic         tag_ready = 1'b0;
   logic         busy;

   int checks = 0;
   int failures = 0;

   cmac_msg_sequencer #(.DATA_W(32)) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .s_data(s_data), .s_bytes(s_bytes), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
      .core_init(core_init), .core_next(core_next), .core_finalize(core_finalize),
      .core_final_size(core_final_size), .core_block(core_block),
      .core_ready(core_ready), .core_valid(core_valid), .core_result(core_result),
      .tag(tag), .tag_valid(tag_valid), .tag_ready(tag_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   localparam logic [511:0] RFC_MSG = {
      128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
      128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
   localparam logic [127:0] TAG_EMPTY = 128'hbb1d6929e95937287fa37d129b756746;
   localparam logic [127:0] TAG_16    = 128'h070a16b46b4d4144f79bdd9dd04a287c;
   localparam logic [127:0] TAG_40    = 128'hdfa66747de9ae63030ca32611497c827;
   localparam logic [127:0] TAG_64    = 128'h51f0bebf7e3b9d92fc49741779363cfe;
   localparam logic [127:0] TAG_17    = 128'h0123456789abcdeffedcba9876543210;

   // Core stand-in: ready drops on init/next, returns after a few cycles, result on final block.
   logic [127:0] m_tag = '0;
   bit           m_valid_en = 1'b1;
   int           m_lat;
   bit           m_op_next, m_fin, cap_fin;
   logic [127:0] cap_block;
   logic [7:0]   cap_size;
   int           n_init = 0, n_next = 0, stable_err = 0;
   logic [127:0] log_block [0:255];
   logic         log_fin   [0:255];
   logic [7:0]   log_size  [0:255];

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         core_ready <= 1'b1; core_valid <= 1'b0; core_result <= '0;
         m_lat <= 0; m_op_next <= 1'b0; m_fin <= 1'b0;
      end else if (core_init) begin
         core_ready <= 1'b0; core_valid <= 1'b0; m_lat <= 3; m_op_next <= 1'b0;
         n_init <= n_init + 1;
      end else if (core_next) begin
         core_ready <= 1'b0; core_valid <= 1'b0; m_lat <= 4; m_op_next <= 1'b1;
         m_fin <= core_finalize;
         cap_block <= core_block; cap_fin <= core_finalize; cap_size <= core_final_size;
         log_block[n_next % 256] <= core_block;
         log_fin[n_next % 256]   <= core_finalize;
         log_size[n_next % 256]  <= core_final_size;
         n_next <= n_next + 1;
      end else if (!core_ready) begin
         if (m_op_next && (core_block !== cap_block || core_finalize !== cap_fin ||
                           core_final_size !== cap_size))
            stable_err <= stable_err + 1;
         if (m_lat > 1) m_lat <= m_lat - 1;
         else begin
            core_ready <= 1'b1;
            if (m_op_next && m_fin) begin
               core_valid  <= m_valid_en;
               core_result <= m_tag;
            end
         end
      end
   end

   logic [7:0] mb [0:79];

   task automatic load_rfc(input int len);
      for (int i = 0; i < 80; i++) mb[i] = (i < len && i < 64) ? RFC_MSG[511 - 8*i -: 8] : 8'h00;
   endtask

   // Streams len bytes from mb as 4-byte words; unused bytes of the last word carry 0xFF junk.
   task automatic send_words(input int len, input bit gaps);
      int nw, nb, guard;
      nw = (len == 0) ? 1 : (len + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         nb = (len - 4*w > 4) ? 4 : len - 4*w;
         for (int b = 0; b < 4; b++) s_data[31 - 8*b -: 8] = (b < nb) ? mb[4*w + b] : 8'hFF;
         s_bytes = 3'(nb);
         s_last  = (w == nw - 1);
         s_valid = 1'b1;
         guard = 0;
         while (!s_ready && guard < 200) begin @(negedge clk); guard++; end
         if (!s_ready) begin
            checks++; failures++;
            $display("FAIL word_accept_timeout word=%0d s_ready=%b required=1", w, s_ready);
            s_valid = 1'b0;
            return;
         end
         @(negedge clk);
         s_valid = 1'b0; s_last = 1'b0;
      end
   endtask

   task automatic run_msg(input string name, input int len, input logic [127:0] core_tag,
                          input bit valid_en, input bit gaps, input int hold,
                          input bit start_noise, input bit take);
      int base_n, base_i, base_s, nb, guard, idx, bi;
      logic [127:0] exp_blk, exp_tag;
      bit stable_ok;
      base_n = n_next; base_i = n_init; base_s = stable_err;
      m_tag = core_tag; m_valid_en = valid_en;
      exp_tag = valid_en ? core_tag : '0;
      nb = (len == 0) ? 1 : (len + 15) / 16;
      start = 1'b1;
      @(negedge clk);
      start = start_noise;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_start got=%b required=1", name, busy); end
      send_words(len, gaps);
      start = 1'b0;
      guard = 0;
      while (!tag_valid && guard < 500) begin @(negedge clk); guard++; end
      checks++;
      if (tag_valid !== 1'b1) begin failures++; $display("FAIL %s tag_valid_timeout got=%b required=1", name, tag_valid); end
      checks++;
      if (tag !== exp_tag) begin failures++; $display("FAIL %s tag got=%h required=%h", name, tag, exp_tag); end
      checks++;
      if (n_init - base_i !== 1) begin failures++; $display("FAIL %s init_count got=%0d required=1", name, n_init - base_i); end
      checks++;
      if (n_next - base_n !== nb) begin failures++; $display("FAIL %s next_count got=%0d required=%0d", name, n_next - base_n, nb); end
      for (int k = 0; k < nb && k < n_next - base_n; k++) begin
         for (int b = 0; b < 16; b++) begin
            bi = 16*k + b;
            exp_blk[127 - 8*b -: 8] = (bi < len) ? mb[bi] : 8'h00;
         end
         idx = (base_n + k) % 256;
         checks++;
         if (log_block[idx] !== exp_blk) begin failures++; $display("FAIL %s block%0d got=%h required=%h", name, k, log_block[idx], exp_blk); end
         checks++;
         if (log_fin[idx] !== (k == nb - 1)) begin failures++; $display("FAIL %s finalize%0d got=%b required=%b", name, k, log_fin[idx], (k == nb - 1)); end
         checks++;
         if (log_size[idx] !== ((k == nb - 1) ? 8'((len - 16*k) * 8) : 8'd128)) begin
            failures++;
            $display("FAIL %s final_size%0d got=%0d required=%0d", name, k, log_size[idx], (k == nb - 1) ? (len - 16*k) * 8 : 128);
         end
      end
      checks++;
      if (stable_err - base_s !== 0) begin failures++; $display("FAIL %s core_outputs_unstable got=%0d required=0", name, stable_err - base_s); end
      if (hold > 0) begin
         stable_ok = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            if (tag !== exp_tag || tag_valid !== 1'b1) stable_ok = 1'b0;
         end
         checks++;
         if (!stable_ok) begin failures++; $display("FAIL %s tag_hold got=%h/%b required=%h/1", name, tag, tag_valid, exp_tag); end
      end
      if (take) begin
         tag_ready = 1'b1; start = start_noise;
         @(negedge clk);
         tag_ready = 1'b0; start = 1'b0;
         checks++;
         if (tag_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL %s tag_taken got=tv%b/busy%b required=tv0/busy0", name, tag_valid, busy);
         end
         if (start_noise) begin
            repeat (3) @(negedge clk);
            checks++;
            if (busy !== 1'b0 || n_init - base_i !== 1) begin
               failures++; $display("FAIL %s no_restart got=busy%b/inits%0d required=busy0/inits1", name, busy, n_init - base_i);
            end
         end
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({s_ready, core_init, core_next, core_finalize, tag_valid, busy} !== 6'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b required=000000", {s_ready, core_init, core_next, core_finalize, tag_valid, busy});
      end
      checks++;
      if (core_block !== '0 || core_final_size !== 8'd0 || tag !== '0) begin
         failures++; $display("FAIL reset_data got=%h/%0d/%h required=0/0/0", core_block, core_final_size, tag);
      end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_empty;
      load_rfc(0);
      run_msg("empty", 0, TAG_EMPTY, 1'b1, 1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_single_block;
      load_rfc(16);
      run_msg("msg16", 16, TAG_16, 1'b1, 1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_multi_block;
      load_rfc(40);
      run_msg("msg40", 40, TAG_40, 1'b1, 1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_gaps_and_hold;
      load_rfc(64);
      run_msg("msg64", 64, TAG_64, 1'b1, 1'b1, 20, 1'b0, 1'b1);
   endtask

   task automatic test_partial_word;
      load_rfc(16);
      mb[16] = 8'hab;
      run_msg("msg17", 17, TAG_17, 1'b1, 1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_start_ignored;
      load_rfc(40);
      run_msg("start_noise", 40, TAG_40, 1'b1, 1'b1, 2, 1'b1, 1'b1);
   endtask

   task automatic test_core_invalid;
      load_rfc(16);
      run_msg("core_invalid", 16, TAG_16, 1'b0, 1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_collect;
      int guard;
      load_rfc(16);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (!s_ready && guard < 50) begin @(negedge clk); guard++; end
      s_data = 32'h6bc1bee2; s_bytes = 3'd4; s_last = 1'b0; s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      checks++;
      if (s_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_collect_state got=rdy%b/busy%b required=1/1", s_ready, busy); end
      resetn = 1'b0;
      #1;
      checks++;
      if ({s_ready, core_init, core_next, core_finalize, tag_valid, busy} !== 6'b0 ||
          core_block !== '0 || core_final_size !== 8'd0 || tag !== '0) begin
         failures++; $display("FAIL reset_mid_collect got=rdy%b/busy%b/blk%h required=all_zero", s_ready, busy, core_block);
      end
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      load_rfc(0);
      run_msg("empty_after_mid_reset", 0, TAG_EMPTY, 1'b1, 1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_in_tag;
      load_rfc(16);
      run_msg("tag_pending", 16, TAG_16, 1'b1, 1'b0, 3, 1'b0, 1'b0);
      resetn = 1'b0;
      #1;
      checks++;
      if (tag_valid !== 1'b0 || tag !== '0 || busy !== 1'b0 || core_block !== '0 || core_finalize !== 1'b0) begin
         failures++; $display("FAIL reset_in_tag got=tv%b/tag%h/busy%b required=0/0/0", tag_valid, tag, busy);
      end
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      load_rfc(0);
      run_msg("empty_after_tag_reset", 0, TAG_EMPTY, 1'b1, 1'b0, 0, 1'b0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_empty();
      test_single_block();
      test_multi_block();
      test_gaps_and_hold();
      test_partial_word();
      test_start_ignored();
      test_core_invalid();
      test_reset_mid_collect();
      test_reset_in_tag();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
